// File: rtl/vga_framebuffer_reader.sv
// vga_framebuffer_reader
//   Pixel stage behind the VGA timing generator. Turns each (X, Y, display)
//   into a read of a 160x120 double-buffered framebuffer and returns the
//   colour. HS/VS/display are delayed by the same amount so they stay
//   aligned with the colour. The front buffer flips only at the VS falling
//   edge, so a frame never tears.
//   Optional feature macro: CURSOR_OVERLAY_EN adds a 4x4 inverting cursor
//   (ports cursor_x / cursor_y in framebuffer coordinates).
module vga_framebuffer_reader #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int X_OFFSET    = 146,
  parameter int SCALE_SHIFT = 2,
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int MEM_LATENCY = 2,
  parameter int COLOR_W     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [9:0]             X,
  input  logic [9:0]             Y,
  input  logic                   display,
  input  logic                   vga_HS_in,
  input  logic                   vga_VS_in,
  output logic [15:0]            fb_addr,
  output logic                   fb_rd_en,
  input  logic [3*COLOR_W-1:0]   fb_rd_data,
  input  logic                   swap_req,
  output logic                   swap_ack,
  output logic                   front_buf,
`ifdef CURSOR_OVERLAY_EN
  input  logic [7:0]             cursor_x,
  input  logic [6:0]             cursor_y,
`endif
  output logic [COLOR_W-1:0]     vga_R,
  output logic [COLOR_W-1:0]     vga_G,
  output logic [COLOR_W-1:0]     vga_B,
  output logic                   vga_HS,
  output logic                   vga_VS,
  output logic                   vga_blank_n
);

  localparam int          SYNC_LEN = MEM_LATENCY + 2;
  localparam int          WORD_W   = 3 * COLOR_W;
  localparam logic [9:0]  XOFF     = 10'(X_OFFSET);
  localparam logic [9:0]  HRES     = 10'(H_RES);
  localparam logic [9:0]  VRES     = 10'(V_RES);
  localparam logic [15:0] BUF_BASE = 16'(FB_W * FB_H);

  // Row offset for a 160-word-wide buffer built from two shifts: fy*160 = fy*128 + fy*32.
  function automatic logic [15:0] fb_index(input logic buf_sel,
                                           input logic [9:0] fx,
                                           input logic [9:0] fy);
    logic [15:0] fy16;
    logic [15:0] row_off;
    fy16    = {6'd0, fy};
    row_off = (fy16 << 7) + (fy16 << 5);
    return (buf_sel ? BUF_BASE : 16'd0) + row_off + {6'd0, fx};
  endfunction

  // Stage A combinational terms
  logic [9:0]  col_a;
  logic [9:0]  fx_a;
  logic [9:0]  fy_a;
  logic        vis_a;
  logic        hit_a;

  // Registered state
  logic [15:0]            fb_addr_q;
  logic                   vis_p0_q;
  logic [MEM_LATENCY-1:0] vis_dly_q;
  logic                   hit_p0_q;
  logic [MEM_LATENCY-1:0] hit_dly_q;
  logic [WORD_W-1:0]      rgb_q, rgb_d;
  logic [SYNC_LEN-1:0]    hs_dly_q, vs_dly_q, de_dly_q;

  logic vs_prev_q;
  logic pending_q, pending_d;
  logic front_buf_q, front_buf_d;
  logic swap_ack_q, swap_ack_d;
  logic do_swap;

  // Stage A: map timing coordinates to framebuffer coordinates and visibility
  always_comb begin
    col_a = X - XOFF;
    vis_a = display && (col_a < HRES) && (Y < VRES);
    fx_a  = col_a >> SCALE_SHIFT;
    fy_a  = Y >> SCALE_SHIFT;
    hit_a = 1'b0;
`ifdef CURSOR_OVERLAY_EN
    hit_a = vis_a
         && (fx_a >= {2'd0, cursor_x}) && (fx_a <= ({2'd0, cursor_x} + 10'd3))
         && (fy_a >= {3'd0, cursor_y}) && (fy_a <= ({3'd0, cursor_y} + 10'd3));
`endif
  end

  // Front-buffer swap decision: only on a VS falling edge with a request outstanding
  always_comb begin
    do_swap     = vs_prev_q && !vga_VS_in && (pending_q || swap_req);
    front_buf_d = front_buf_q ^ do_swap;
    swap_ack_d  = do_swap;
    pending_d   = do_swap ? 1'b0 : (pending_q || swap_req);
  end

  // Stage C: colour select, blanked outside the visible area, inverted under the cursor
  always_comb begin
    rgb_d = '0;
    if (vis_dly_q[MEM_LATENCY-1]) begin
      rgb_d = hit_dly_q[MEM_LATENCY-1] ? ~fb_rd_data : fb_rd_data;
    end
  end

  // Pipeline, delay lines and swap state
  always_ff @(posedge clk) begin
    if (reset) begin
      fb_addr_q   <= '0;
      vis_p0_q    <= 1'b0;
      hit_p0_q    <= 1'b0;
      vis_dly_q   <= '0;
      hit_dly_q   <= '0;
      rgb_q       <= '0;
      hs_dly_q    <= '1;
      vs_dly_q    <= '1;
      de_dly_q    <= '0;
      vs_prev_q   <= 1'b1;
      pending_q   <= 1'b0;
      front_buf_q <= 1'b0;
      swap_ack_q  <= 1'b0;
    end else begin
      // stage A -> memory request
      if (vis_a) begin
        fb_addr_q <= fb_index(front_buf_q, fx_a, fy_a);
      end
      vis_p0_q <= vis_a;
      hit_p0_q <= hit_a;
      // stage B: visibility and cursor hit ride alongside the memory latency
      vis_dly_q[0] <= vis_p0_q;
      hit_dly_q[0] <= hit_p0_q;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        vis_dly_q[i] <= vis_dly_q[i-1];
        hit_dly_q[i] <= hit_dly_q[i-1];
      end
      // stage C -> colour register
      rgb_q <= rgb_d;
      // sync/display delay line matching the colour path
      hs_dly_q[0] <= vga_HS_in;
      vs_dly_q[0] <= vga_VS_in;
      de_dly_q[0] <= display;
      for (int i = 1; i < SYNC_LEN; i++) begin
        hs_dly_q[i] <= hs_dly_q[i-1];
        vs_dly_q[i] <= vs_dly_q[i-1];
        de_dly_q[i] <= de_dly_q[i-1];
      end
      vs_prev_q   <= vga_VS_in;
      pending_q   <= pending_d;
      front_buf_q <= front_buf_d;
      swap_ack_q  <= swap_ack_d;
    end
  end

  assign fb_addr     = fb_addr_q;
  assign fb_rd_en    = vis_p0_q;
  assign front_buf   = front_buf_q;
  assign swap_ack    = swap_ack_q;
  assign vga_R       = rgb_q[3*COLOR_W-1:2*COLOR_W];
  assign vga_G       = rgb_q[2*COLOR_W-1:COLOR_W];
  assign vga_B       = rgb_q[COLOR_W-1:0];
  assign vga_HS      = hs_dly_q[SYNC_LEN-1];
  assign vga_VS      = vs_dly_q[SYNC_LEN-1];
  assign vga_blank_n = de_dly_q[SYNC_LEN-1];

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Testbench for vga_framebuffer_reader: random and directed timing inputs,
// a framebuffer memory model, and a scoreboard of expected outputs.
module tb_vga_framebuffer_reader;

  localparam int L      = 2;
  localparam int LAT    = L + 2;
  localparam int NWORDS = 2 * 160 * 120;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [9:0]  X = '0, Y = '0;
  logic        display = 1'b0, hs_in = 1'b1, vs_in = 1'b1, swap_req = 1'b0;
  logic [15:0] fb_addr;
  logic        fb_rd_en;
  logic [8:0]  fb_rd_data;
  logic        swap_ack, front_buf;
  logic [2:0]  vga_R, vga_G, vga_B;
  logic        vga_HS, vga_VS, vga_blank_n;
`ifdef CURSOR_OVERLAY_EN
  logic [7:0]  cursor_x = 8'd10;
  logic [6:0]  cursor_y = 7'd5;
`endif

  vga_framebuffer_reader #(.MEM_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .X(X), .Y(Y), .display(display),
    .vga_HS_in(hs_in), .vga_VS_in(vs_in),
    .fb_addr(fb_addr), .fb_rd_en(fb_rd_en), .fb_rd_data(fb_rd_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .front_buf(front_buf),
`ifdef CURSOR_OVERLAY_EN
    .cursor_x(cursor_x), .cursor_y(cursor_y),
`endif
    .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B),
    .vga_HS(vga_HS), .vga_VS(vga_VS), .vga_blank_n(vga_blank_n)
  );

  // Framebuffer memory: data for the address presented appears L cycles later
  logic [8:0] mem [NWORDS];
  logic [8:0] rd_pipe [L];
  always @(posedge clk) begin
    rd_pipe[0] <= (fb_addr < 16'(NWORDS)) ? mem[fb_addr] : 9'd0;
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign fb_rd_data = rd_pipe[L-1];

  typedef struct { int due; logic [8:0] rgb; logic hs; logic vs; logic de; } pix_t;
  typedef struct { int due; logic [15:0] addr; logic rd_en; logic ack; logic front; } ctl_t;
  pix_t pixq[$];
  ctl_t ctlq[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference state, expressed in screen/framebuffer terms
  int   m_addr    = 0;
  logic m_front   = 1'b0;
  logic m_pending = 1'b0;
  logic m_vsprev  = 1'b1;

  // One cycle of stimulus; expected responses queued for the monitor
  task automatic issue(input logic rst, input int x, input int y, input logic de,
                       input logic hs, input logic vs, input logic sreq);
    int   n, col, fx, fy;
    logic vis, dosw, hit;
    logic [8:0] word;
    @(posedge clk);
    #1;
    reset = rst; X = 10'(x); Y = 10'(y); display = de;
    hs_in = hs; vs_in = vs; swap_req = sreq;
    n = cyc;
    if (rst) begin
      foreach (pixq[i]) begin
        if (pixq[i].due > n) begin
          pixq[i].rgb = 9'd0; pixq[i].hs = 1'b1; pixq[i].vs = 1'b1; pixq[i].de = 1'b0;
        end
      end
      pixq.push_back(pix_t'{n + LAT, 9'd0, 1'b1, 1'b1, 1'b0});
      ctlq.push_back(ctl_t'{n + 1, 16'd0, 1'b0, 1'b0, 1'b0});
      m_addr = 0; m_front = 1'b0; m_pending = 1'b0; m_vsprev = 1'b1;
    end else begin
      col = (x - 146) & 1023;
      vis = de && (col < 640) && (y < 480);
      fx  = col / 4;
      fy  = y / 4;
      if (vis) m_addr = (m_front ? 19200 : 0) + fy * 160 + fx;
      word = vis ? mem[m_addr] : 9'd0;
      hit  = 1'b0;
`ifdef CURSOR_OVERLAY_EN
      hit = vis && (fx >= int'(cursor_x)) && (fx <= int'(cursor_x) + 3)
                && (fy >= int'(cursor_y)) && (fy <= int'(cursor_y) + 3);
`endif
      if (hit) word = ~word;
      dosw = m_vsprev && !vs && (m_pending || sreq);
      if (dosw) m_front = ~m_front;
      m_pending = dosw ? 1'b0 : (m_pending || sreq);
      m_vsprev  = vs;
      pixq.push_back(pix_t'{n + LAT, word, hs, vs, de});
      ctlq.push_back(ctl_t'{n + 1, 16'(m_addr), vis, dosw, m_front});
    end
  endtask

  // Monitor: compares DUT outputs against queued expectations away from the clock edge
  always @(negedge clk) begin
    pix_t p;
    ctl_t c;
    if (pixq.size() > 0 && pixq[0].due <= cyc) begin
      p = pixq.pop_front();
      checks++;
      if (p.due != cyc || {vga_R, vga_G, vga_B} !== p.rgb || vga_HS !== p.hs ||
          vga_VS !== p.vs || vga_blank_n !== p.de) begin
        errors++;
        $display("FAIL pixel cyc=%0d due=%0d got rgb=%03h hs=%b vs=%b de=%b want rgb=%03h hs=%b vs=%b de=%b",
                 cyc, p.due, {vga_R, vga_G, vga_B}, vga_HS, vga_VS, vga_blank_n,
                 p.rgb, p.hs, p.vs, p.de);
      end
    end
    if (ctlq.size() > 0 && ctlq[0].due <= cyc) begin
      c = ctlq.pop_front();
      checks++;
      if (c.due != cyc || fb_addr !== c.addr || fb_rd_en !== c.rd_en ||
          swap_ack !== c.ack || front_buf !== c.front) begin
        errors++;
        $display("FAIL ctrl cyc=%0d due=%0d got addr=%0d rd_en=%b ack=%b front=%b want addr=%0d rd_en=%b ack=%b front=%b",
                 cyc, c.due, fb_addr, fb_rd_en, swap_ack, front_buf,
                 c.addr, c.rd_en, c.ack, c.front);
      end
    end
  end

  initial begin
    logic vs_lvl;
    for (int i = 0; i < NWORDS; i++) mem[i] = 9'($urandom);
    mem[0]     = 9'h1FF;
    mem[1132]  = 9'h0F0;
    mem[19199] = 9'h155;
    mem[38399] = 9'h0AA;

    // reset for three clocks
    repeat (3) issue(1, 0, 0, 0, 1, 1, 0);

    // first pixel, last pixel, blanked and off-screen positions
    issue(0, 146, 0, 1, 1, 1, 0);
    issue(0, 785, 479, 1, 1, 1, 0);
    issue(0, 100, 10, 1, 1, 1, 0);
    issue(0, 300, 10, 0, 1, 1, 0);
    issue(0, 194, 28, 1, 1, 1, 0);
    issue(0, 200, 3, 0, 0, 1, 0);
    issue(0, 200, 3, 0, 1, 0, 0);
    issue(0, 200, 3, 0, 1, 1, 0);

    // two swap pulses mid-frame, then a VS fall: exactly one flip
    issue(0, 400, 100, 1, 1, 1, 1);
    repeat (3) issue(0, 401, 100, 1, 1, 1, 0);
    issue(0, 402, 100, 1, 1, 1, 1);
    repeat (3) issue(0, 403, 101, 1, 1, 1, 0);
    issue(0, 10, 490, 0, 1, 0, 0);
    repeat (3) issue(0, 10, 491, 0, 1, 0, 0);
    issue(0, 10, 492, 0, 1, 1, 0);
    issue(0, 10, 493, 0, 1, 0, 0);
    issue(0, 10, 494, 0, 1, 1, 0);
    issue(0, 785, 479, 1, 1, 1, 0);
    issue(0, 146, 0, 1, 1, 1, 0);

    // swap request lost to a mid-line reset
    issue(0, 300, 50, 1, 1, 1, 1);
    issue(0, 301, 50, 1, 0, 1, 0);
    issue(1, 302, 50, 1, 1, 1, 0);
    repeat (2) issue(0, 303, 50, 1, 1, 1, 0);
    issue(0, 10, 490, 0, 1, 0, 0);
    issue(0, 10, 491, 0, 1, 1, 0);

    // swap_req held through the ack re-arms for the next VS fall
    issue(0, 10, 492, 0, 1, 0, 1);
    issue(0, 10, 493, 0, 1, 1, 1);
    issue(0, 10, 494, 0, 1, 0, 0);
    issue(0, 10, 495, 0, 1, 1, 0);

    // randomized traffic
    vs_lvl = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) vs_lvl = ~vs_lvl;
      issue(($urandom_range(0, 599) == 0),
            $urandom_range(90, 800), $urandom_range(0, 525),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0),
            vs_lvl, ($urandom_range(0, 29) == 0));
    end

    repeat (LAT + 2) issue(0, 0, 0, 0, 1, 1, 0);
    repeat (LAT + 2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (pixq.size() != 0 || ctlq.size() != 0) begin
      errors++;
      $display("FAIL drain got pix_left=%0d ctl_left=%0d want 0", pixq.size(), ctlq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
